// File: rtl/rr_push_arbiter.sv
// rr_push_arbiter: buffers one packet per requester and issues at most one
// push per cycle into the stage-0 FIFO. Requesters are served round-robin.
// The block never pushes while the downstream FIFO reports full.
module rr_push_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int QWID  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_vld,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_rdy,
  input  logic                  full,
  output logic                  push,
  output logic [WIDTH-1:0]      data_out,
  output logic [QWID-1:0]       grant_idx,
  output logic [NREQ-1:0]       pending
);

  logic [NREQ-1:0]  hold_vld;
  logic [WIDTH-1:0] hold_data [NREQ];
  logic [QWID-1:0]  rr_ptr;

  logic [QWID-1:0]  winner;
  logic [QWID-1:0]  search_idx;
  logic             found;
  logic             push_int;
  logic [NREQ-1:0]  grant;
  logic [NREQ-1:0]  xfer;

  // Round-robin search: first occupied slot starting at rr_ptr, wrapping
  // naturally in QWID bits.
  always_comb begin
    winner     = '0;
    search_idx = '0;
    found      = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      search_idx = rr_ptr + QWID'(k);
      if (!found && hold_vld[search_idx]) begin
        winner = search_idx;
        found  = 1'b1;
      end
    end
  end

  // Push/grant/ready decode. Reset masks every output so the harness sees a
  // quiet, fully-ready block for the whole reset interval.
  always_comb begin
    push_int  = found && !full && !rst;
    grant     = push_int ? (NREQ'(1) << winner) : '0;
    req_rdy   = rst ? '1 : (~hold_vld | grant);
    xfer      = req_vld & req_rdy;
    push      = push_int;
    data_out  = push_int ? hold_data[winner] : '0;
    grant_idx = push_int ? winner : '0;
    pending   = rst ? '0 : hold_vld;
  end

  // Control state: slot occupancy and round-robin pointer. A refill wins over
  // a drain so a slot can be emptied and reloaded in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld <= '0;
      rr_ptr   <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (xfer[i])       hold_vld[i] <= 1'b1;
        else if (grant[i]) hold_vld[i] <= 1'b0;
      end
      if (push_int) rr_ptr <= winner + QWID'(1);
    end
  end

  // Packet storage: captured on every accepted transfer, never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (xfer[i]) hold_data[i] <= req_data[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: tb/tb_rr_push_arbiter.sv
// Bench for rr_push_arbiter: directed scenarios with literal expectations,
// then randomized traffic against a queue-based reference model.
module tb_rr_push_arbiter;
  localparam int W = 8;
  localparam int N = 4;
  localparam int Q = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_vld;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_rdy;
  logic           full;
  logic           push;
  logic [W-1:0]   data_out;
  logic [Q-1:0]   grant_idx;
  logic [N-1:0]   pending;

  rr_push_arbiter #(.WIDTH(W), .NREQ(N), .QWID(Q)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_data(req_data),
    .req_rdy(req_rdy), .full(full), .push(push), .data_out(data_out),
    .grant_idx(grant_idx), .pending(pending)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: each requester owns a queue (holding at most one packet)
  // plus a round-robin start position.
  logic [W-1:0] m_q [N][$];
  int           m_ptr = 0;

  function automatic int m_winner();
    for (int k = 0; k < N; k++)
      if (m_q[(m_ptr + k) % N].size() > 0) return (m_ptr + k) % N;
    return -1;
  endfunction

  always @(posedge clk) begin
    int  w;
    bit  p;
    bit  acc;
    if (rst) begin
      for (int i = 0; i < N; i++) m_q[i].delete();
      m_ptr = 0;
    end else begin
      w = m_winner();
      p = (w >= 0) && !full;
      for (int i = 0; i < N; i++) begin
        acc = req_vld[i] && (m_q[i].size() == 0 || (p && w == i));
        if (p && w == i) void'(m_q[i].pop_front());
        if (acc) m_q[i].push_back(req_data[i*W +: W]);
      end
      if (p) m_ptr = (w + 1) % N;
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    int           w;
    bit           ep;
    logic [N-1:0] e_rdy;
    logic [N-1:0] e_pend;
    logic [W-1:0] e_data;
    w  = m_winner();
    ep = !rst && (w >= 0) && !full;
    e_data = ep ? m_q[w][0] : '0;
    for (int i = 0; i < N; i++) begin
      e_pend[i] = !rst && (m_q[i].size() > 0);
      e_rdy[i]  = rst || (m_q[i].size() == 0) || (ep && w == i);
    end
    chk("model_push", push, ep);
    chk("model_grant_idx", grant_idx, ep ? w : 0);
    chk("model_data_out", data_out, e_data);
    chk("model_req_rdy", req_rdy, e_rdy);
    chk("model_pending", pending, e_pend);
    if (push && full) chk("push_while_full", 1, 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input int i, input logic [W-1:0] v);
    req_data[i*W +: W] = v;
  endtask

  task automatic exp_push(input string nm, input int g, input logic [W-1:0] d);
    @(negedge clk);
    chk({nm, "_push"}, push, 1);
    chk({nm, "_grant"}, grant_idx, g);
    chk({nm, "_data"}, data_out, d);
  endtask

  initial begin
    rst = 1'b1; full = 1'b0; req_vld = 4'hF; req_data = $urandom;
    // Reset held two cycles with all requesters valid
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_push", push, 0);
      chk("rst_pending", pending, 0);
      chk("rst_rdy", req_rdy, 4'b1111);
      tick();
    end
    rst = 1'b0; req_vld = '0;
    @(negedge clk);
    chk("post_rst_pending", pending, 0);
    chk("post_rst_push", push, 0);

    // Round-robin wrap, twice
    for (int r = 0; r < 2; r++) begin
      tick();
      req_vld = 4'hF;
      for (int i = 0; i < N; i++) set_d(i, 8'hA0 + i);
      tick();
      req_vld = '0;
      for (int i = 0; i < N; i++) begin
        exp_push("rr", i, 8'hA0 + i);
        tick();
      end
    end

    // Single requester streaming on index 2
    req_vld = 4'b0100; set_d(2, 8'h10);
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k < 3) set_d(2, 8'h10 + k); else req_vld = '0;
      exp_push("stream", 2, 8'h10 + k - 1);
      chk("stream_rdy2", req_rdy[2], 1);
    end
    tick();
    @(negedge clk);
    chk("stream_idle_push", push, 0);

    // Pointer start: steer pointer to 2, then slots 1 and 3 occupied
    tick();
    req_vld = 4'b0010; set_d(1, 8'hC1);
    tick();
    req_vld = 4'b1010; set_d(1, 8'hC2); set_d(3, 8'hC3);
    exp_push("ptr_a", 1, 8'hC1);
    tick();
    req_vld = '0;
    exp_push("ptr_b", 3, 8'hC3);
    tick();
    exp_push("ptr_c", 1, 8'hC2);

    // Backpressure with slots 0 and 1 loaded
    tick();
    req_vld = 4'b0011; set_d(0, 8'hB0); set_d(1, 8'hB1); full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      req_vld = '0;
      @(negedge clk);
      chk("bp_push", push, 0);
      chk("bp_rdy", req_rdy, 4'b1100);
      chk("bp_pending", pending, 4'b0011);
    end
    tick();
    full = 1'b0;
    exp_push("bp_a", 0, 8'hB0);
    tick();
    exp_push("bp_b", 1, 8'hB1);

    // Randomized traffic, backpressure and occasional reset
    for (int c = 0; c < 3000; c++) begin
      tick();
      req_vld  = N'($urandom);
      req_data = $urandom;
      full     = ($urandom_range(0, 3) == 0);
      rst      = ($urandom_range(0, 199) == 0);
    end
    tick();
    req_vld = '0; full = 1'b0; rst = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    chk("drain_pending", pending, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rr_push_arbiter.md
# rr_push_arbiter

Upstream feeder for the two-stage FIFO/scoreboard chain. Collects packets from `NREQ` independent requesters, buffers one packet per requester, and issues at most one push per cycle into the first-stage FIFO (`push`/`data_in`/`full` of stage 0) using round-robin arbitration. Guarantees the chain's push-side contract by construction: never pushes while `full` is high, so the `!push || !full` constraint holds as a property of this block rather than an environment constraint.

## Interface
- `WIDTH`, default `FIFO_DWIDTH` (8): packet width; must match the downstream FIFO.
- `NREQ`, default 4: number of requesters; power of two, ≥ 2.
- `QWID`, default `ARB_QWID` (2): grant index width, equals log2(`NREQ`).

- `clk`  in  1  sole clock; all state updates on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_vld`  in  `NREQ`  per-requester packet valid.
- `req_data`  in  `NREQ*WIDTH`  packets; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_rdy`  out  `NREQ`  per-requester ready; transfer on `req_vld[i] && req_rdy[i]` at posedge.
- `full`  in  1  downstream FIFO full.
- `push`  out  1  push strobe to downstream FIFO.
- `data_out`  out  `WIDTH`  packet accompanying `push`; drives stage-0 `data_in`.
- `grant_idx`  out  `QWID`  index of requester served by current `push`; 0 when `push` low.
- `pending`  out  `NREQ`  hold-slot occupancy, for the harness.

## Operation
- State: per requester one hold slot (`hold_vld[i]`, `hold_data[i]`); round-robin pointer `rr_ptr` (`QWID` bits).
- Reset (`rst` high at posedge): all `hold_vld` cleared, `rr_ptr` ← 0. Hold data need not be cleared. While/after reset: `push`=0, `grant_idx`=0, `data_out`=0, `pending`=0, `req_rdy`=all ones. Reset overrides any same-cycle transfer; packets presented in the reset cycle are dropped.
- Arbitration (combinational): candidates = `hold_vld`. Winner = first i with `hold_vld[i]` searching `rr_ptr`, `rr_ptr+1`, … modulo `NREQ` (wrap-around). `push` = any candidate && !`full`. `data_out` = winner's hold data when `push`, else 0.
- Grant: `grant[i]` = `push` && winner == i.
- Ready: `req_rdy[i]` = !`hold_vld[i]` || `grant[i]` (slot may be drained and refilled in the same cycle).
- Slot update per i at posedge: transfer → `hold_vld` 1, `hold_data` ← `req_data[i]`; else `grant[i]` → `hold_vld` 0; else hold.
- Pointer: on `push`, `rr_ptr` ← winner+1 (mod `NREQ`, natural wrap in `QWID` bits). No push → unchanged.
- `full` high: no push, no slot drains, pointer frozen; occupied slots deassert `req_rdy`; empty slots still accept.
- Packets from one requester leave in acceptance order; no packet is dropped or duplicated outside reset.

## Timing
- Latency: packet accepted at posedge t is visible in `pending` and eligible for `push` in cycle t+1 (after t) — one-cycle minimum latency.
- `push`, `data_out`, `grant_idx`, `req_rdy` combinational from state and `full`; no path from `req_vld`/`req_data` to any output.
- Throughput: one push per cycle while any slot occupied and `full` low; one requester sustains 1 packet/cycle when alone.
- Fairness: continuously requesting requester granted within `NREQ` pushes.

## Test plan
- Reset: assert `rst` 2 cycles with all `req_vld`=1 → `push`=0, `pending`=0, `req_rdy`=4'b1111; first push after release grants index 0.
- Single requester streaming: `req_vld`=4'b0100, data 0x10,0x11,0x12 back-to-back, `full`=0 → `push` high cycles 1–3, `data_out` 0x10,0x11,0x12, `grant_idx`=2 each cycle, `req_rdy[2]` stays 1.
- Round-robin wrap: all four slots loaded (data 0xA0+i), `full`=0, no new requests → grants 0,1,2,3 on consecutive cycles; reload all, `rr_ptr`=0 again → order 0,1,2,3.
- Pointer start: only slots 1 and 3 occupied, `rr_ptr`=2 → grant 3 then 1.
- Backpressure: slots 0,1 loaded, `full`=1 for 3 cycles → `push`=0, `req_rdy`=4'b1100, pointer unchanged; `full` drops → grants 0 then 1, data intact.
- Chained formal: drive stage-0 inputs of the FIFO/scoreboard chain from this block → end-to-end scoreboard property holds and `!push || !full` never violated.
